dvp_frame_gen: RTL

// - Synthesisable, parametrised DVP (OV7725-style) camera source.
// - Emits vsync/href/data frames with RGB565 test patterns selectable at run time.
// - Used by the capture path bring-up benches and by on-board self-test, with the output muxed in front of the capture front end.
// - Over a fixed stimulus model it adds: configurable geometry/timing, a pixel-clock enable, 8/16-bit bus, four patterns, clean start/stop.

---
 rtl/dvp_gen_pkg.sv | 37 +++
 rtl/dvp_pattern_pix.sv | 43 ++++
 rtl/dvp_frame_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dvp_gen_pkg.sv
// Shared definitions for the DVP test-pattern source.
//   mode_e       : run-time pattern select (colour bars, gradient, checker, PRBS)
//   ST_*         : frame FSM state encodings
//   LFSR_SEED    : PRBS start value, reloaded at every frame start
//   LFSR_TAPS    : feedback taps of the right-shifting Fibonacci LFSR
//   bar_colour() : RGB565 colour table for the eight colour bars
//   lfsr_step()  : one PRBS advance
package dvp_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_PRBS  = 2'd3
  } mode_e;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_VS   = 3'd1;
  localparam logic [2:0] ST_VB   = 3'd2;
  localparam logic [2:0] ST_ACT  = 3'd3;
  localparam logic [2:0] ST_HB   = 3'd4;
  localparam logic [2:0] ST_VF   = 3'd5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Polynomial x^16+x^14+x^13+x^11+1 on a right-shifting register: the
  // feedback is the XOR of bits 0, 2, 3 and 5, shifted in at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] bar_colour(input logic [2:0] k);
    return {(k[2] ? 5'h1F : 5'h00), (k[1] ? 6'h3F : 6'h00), (k[0] ? 5'h1F : 5'h00)};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/dvp_pattern_pix.sv
// Combinational RGB565 pattern generator.
//   mode [1:0]  : pattern select (mode_e encoding)
//   x    [15:0] : pixel column, 0..H_ACTIVE-1
//   y    [15:0] : pixel row, 0..V_ACTIVE-1
//   lfsr [15:0] : current PRBS value, used directly as the pixel in PRBS mode
//   pix  [15:0] : RGB565 pixel
module dvp_pattern_pix
  import dvp_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [1:0]  mode,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] lfsr,
  output logic [15:0] pix
);

  // Bars are H_ACTIVE/8 wide; a remainder from a non-multiple width is
  // absorbed by the last bar.
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [15:0] bar_idx;
  logic [2:0]  bar_k;
  logic        unused_y;

  assign unused_y = ^y[15:6];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    pix     = 16'h0000;
    bar_idx = x / 16'(BAR_W);
    bar_k   = (bar_idx > 16'd7) ? 3'd7 : bar_idx[2:0];
    case (mode)
      MODE_BARS:  pix = bar_colour(bar_k);
      MODE_GRAD:  pix = {x[4:0], y[5:0], x[4:0]};
      MODE_CHECK: pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
      default:    pix = lfsr;
    endcase
  end

endmodule

// File: rtl/dvp_frame_gen.sv
// Parametrised DVP (OV7725-style) camera source with RGB565 test patterns.
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   ce         : pixel-clock enable; nothing advances while low
//   en         : run request, sampled only at frame start
//   mode [1:0] : pattern select, sampled only at frame start
//   vsync      : frame sync, active high
//   href       : line valid, active high
//   data       : pixel byte (DATA_W=8, high byte first) or word (DATA_W=16)
//   frame_cnt  : completed frames, wraps
//   busy       : high from frame start until frame end
// The next-beat values are computed combinationally and the outputs are
// registered from them, so the outputs always describe the beat that the
// registered state represents. All durations must be at least one beat.
module dvp_frame_gen
  import dvp_gen_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic              vsync,
  output logic              href,
  output logic [DATA_W-1:0] data,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int BPP    = 16 / DATA_W;
  localparam int ACT_T  = H_ACTIVE * BPP;
  localparam int LINE_T = ACT_T + H_BLANK;
  localparam int VS_T   = VSYNC_LINES * LINE_T;
  localparam int VB_T   = V_BACK * LINE_T;
  localparam int VF_T   = V_FRONT * LINE_T;
  localparam int MAX_A  = (VS_T > VB_T) ? VS_T : VB_T;
  localparam int MAX_B  = (VF_T > LINE_T) ? VF_T : LINE_T;
  localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VS_T - 1);
  localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(VB_T - 1);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(ACT_T - 1);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VF_LAST  = CNT_W'(VF_T - 1);
  localparam logic [15:0]      Y_LAST   = 16'(V_ACTIVE - 1);

  logic [2:0]       state, n_state;
  logic [CNT_W-1:0] cnt, n_cnt;
  logic [15:0]      y, n_y;
  logic [15:0]      lfsr, n_lfsr;
  logic [1:0]       mode_q, n_mode;
  logic             frame_done;
  logic             pix_last;
  logic [15:0]      n_x;
  logic [15:0]      pix;
  logic [DATA_W-1:0] beat_word;

  // Last beat of a pixel: every beat on a 16-bit bus, the low byte on 8-bit.
  assign pix_last = (BPP == 1) || cnt[0];

  always_comb begin
    n_state    = state;
    n_cnt      = cnt + CNT_W'(1);
    n_y        = y;
    n_lfsr     = lfsr;
    n_mode     = mode_q;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        n_cnt = '0;
        if (en) begin
          n_state = ST_VS;
          n_lfsr  = LFSR_SEED;
          n_mode  = mode;
        end
      end
      ST_VS: if (cnt == VS_LAST) begin
        n_state = ST_VB;
        n_cnt   = '0;
      end
      ST_VB: if (cnt == VB_LAST) begin
        n_state = ST_ACT;
        n_cnt   = '0;
      end
      ST_ACT: begin
        if (pix_last) n_lfsr = lfsr_step(lfsr);
        if (cnt == ACT_LAST) begin
          n_state = ST_HB;
          n_cnt   = '0;
        end
      end
      ST_HB: if (cnt == HB_LAST) begin
        n_cnt = '0;
        if (y == Y_LAST) begin
          n_state = ST_VF;
          n_y     = '0;
        end else begin
          n_state = ST_ACT;
          n_y     = y + 16'd1;
        end
      end
      ST_VF: if (cnt == VF_LAST) begin
        n_cnt      = '0;
        frame_done = 1'b1;
        if (en) begin
          n_state = ST_VS;
          n_lfsr  = LFSR_SEED;
          n_mode  = mode;
        end else begin
          n_state = ST_IDLE;
        end
      end
      default: begin
        n_state = ST_IDLE;
        n_cnt   = '0;
      end
    endcase
  end

  assign n_x = 16'(n_cnt >> (BPP - 1));

  dvp_pattern_pix #(
    .H_ACTIVE(H_ACTIVE)
  ) u_pix (
    .mode(n_mode),
    .x   (n_x),
    .y   (n_y),
    .lfsr(n_lfsr),
    .pix (pix)
  );

  generate
    if (DATA_W == 8) begin : g_byte
      logic n_phase;
      assign n_phase   = n_cnt[0];
      assign beat_word = n_phase ? pix[7:0] : pix[15:8];
    end else begin : g_word
      assign beat_word = pix;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      y         <= '0;
      lfsr      <= LFSR_SEED;
      mode_q    <= MODE_BARS;
      vsync     <= 1'b0;
      href      <= 1'b0;
      data      <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
    end else if (ce) begin
      state  <= n_state;
      cnt    <= n_cnt;
      y      <= n_y;
      lfsr   <= n_lfsr;
      mode_q <= n_mode;
      vsync  <= (n_state == ST_VS);
      href   <= (n_state == ST_ACT);
      data   <= (n_state == ST_ACT) ? beat_word : '0;
      busy   <= (n_state != ST_IDLE);
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
